// File: rtl/bd_mem_pkg.sv
// bd_mem_pkg: shared state encoding and default geometry for the backdoor memory controller.
package bd_mem_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 64;

    typedef enum logic {INIT, IDLE} state_t;

endpackage

// File: rtl/bd_mem_array.sv
// bd_mem_array: word array with one byte-enabled write port and one asynchronous read port.
module bd_mem_array
    import bd_mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    wstrb,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents are established by the controller's clearing pass.
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < WIDTH/8; i++)
                if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

    assign rdata = mem[raddr];

endmodule

// File: rtl/bd_mem_ctrl.sv
// bd_mem_ctrl: single-port memory controller with a clearing pass, a byte-enabled
// front door and a priority backdoor; rst is asynchronous and active-low.
module bd_mem_ctrl
    import bd_mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH/8-1:0]    strb,
    input  logic                  clr,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  rvalid,
    output logic                  err,
    input  logic                  bd_en,
    input  logic                  bd_wr,
    input  logic [ADDR_WIDTH-1:0] bd_addr,
    input  logic [WIDTH-1:0]      bd_wdata,
    output logic [WIDTH-1:0]      bd_rdata,
    output logic                  bd_ready
);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
    logic                  idle, acc, last, in_rng, bd_in_rng, we;
    logic [ADDR_WIDTH-1:0] waddr, raddr;
    logic [WIDTH-1:0]      wd, mem_rd;
    logic [WIDTH/8-1:0]    ws;

    assign idle      = state == IDLE;
    assign ready     = idle && !bd_en && !clr;
    assign bd_ready  = idle;
    assign acc       = valid && ready;
    assign last      = cnt == ADDR_WIDTH'(DEPTH - 1);
    assign in_rng    = 32'(addr) < DEPTH;
    assign bd_in_rng = 32'(bd_addr) < DEPTH;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!idle) begin
            state_nx = last ? IDLE : INIT;
            cnt_nx   = last ? '0 : cnt + 1'b1;
        end else if (clr) begin
            state_nx = INIT;
            cnt_nx   = '0;
        end
    end

    // Single write port: clearing pass, then backdoor, then front door.
    always_comb begin
        we    = !idle || (bd_en ? bd_wr && bd_in_rng : acc && wr_rd && in_rng);
        waddr = !idle ? cnt : bd_en ? bd_addr : addr;
        wd    = !idle ? '0 : bd_en ? bd_wdata : wdata;
        ws    = (!idle || bd_en) ? '1 : strb;
        raddr = bd_en ? bd_addr : addr;
    end

    bd_mem_array #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wd),
        .wstrb (ws),
        .raddr (raddr),
        .rdata (mem_rd)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state    <= INIT;
            cnt      <= '0;
            rvalid   <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            bd_rdata <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            rvalid <= acc && !wr_rd;
            err    <= acc && !in_rng;
            if (acc && !wr_rd) rdata <= in_rng ? mem_rd : '0;
            if (idle && bd_en && !bd_wr) bd_rdata <= bd_in_rng ? mem_rd : '0;
        end

endmodule

// File: tb/tb_bd_mem_ctrl.sv
// tb_bd_mem_ctrl: drives a DEPTH=64 and a DEPTH=48 controller with shared stimulus and
// checks both against an array-based reference model, directed vectors and corner sequences.
module tb_bd_mem_ctrl;

    logic        clk, rst, valid, wr_rd, clr, bd_en, bd_wr;
    logic [5:0]  addr, bd_addr;
    logic [15:0] wdata, bd_wdata;
    logic [1:0]  strb;
    logic [1:0]  rdy, rv, er, bdr;
    logic [1:0][15:0] rd, bdd;

    int ncmp = 0;
    int nfail = 0;

    int          dep [2] = '{64, 48};
    int          busy [2];
    logic [15:0] m [2][64];
    logic [15:0] e_rd [2];
    logic [15:0] e_bd [2];
    logic        e_rv [2];
    logic        e_err [2];

    typedef struct {
        logic        v, w;
        logic [5:0]  a;
        logic [15:0] wd;
        logic [1:0]  s;
        logic        be, bw;
        logic [5:0]  ba;
        logic [15:0] bwd;
        logic        c;
        logic [15:0] x_rd;
        logic        x_rv, x_err;
        logic [15:0] x_bd;
    } vec_t;

    vec_t tbl [13];

    bd_mem_ctrl u64 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .strb(strb), .clr(clr), .ready(rdy[0]), .rdata(rd[0]), .rvalid(rv[0]), .err(er[0]),
        .bd_en(bd_en), .bd_wr(bd_wr), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bdd[0]), .bd_ready(bdr[0])
    );

    bd_mem_ctrl #(.DEPTH(48)) u48 (
        .clk(clk), .rst(rst), .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .strb(strb), .clr(clr), .ready(rdy[1]), .rdata(rd[1]), .rvalid(rv[1]), .err(er[1]),
        .bd_en(bd_en), .bd_wr(bd_wr), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bdd[1]), .bd_ready(bdr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string n, int d, logic [15:0] a, logic [15:0] e);
        ncmp++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s depth%0d t=%0t got %h want %h", n, dep[d], $time, a, e);
        end
    endtask

    function automatic vec_t mk(bit v, bit w, int a, int wd, int s, bit be, bit bw, int ba,
                                int bwd, bit c, int xrd, bit xrv, bit xerr, int xbd);
        vec_t r;
        r.v = v; r.w = w; r.a = 6'(a); r.wd = 16'(wd); r.s = 2'(s);
        r.be = be; r.bw = bw; r.ba = 6'(ba); r.bwd = 16'(bwd); r.c = c;
        r.x_rd = 16'(xrd); r.x_rv = xrv; r.x_err = xerr; r.x_bd = 16'(xbd);
        return r;
    endfunction

    // Reference: a busy countdown per instance stands in for the clearing pass.
    task automatic model();
        for (int d = 0; d < 2; d++) begin
            int D = dep[d];
            if (busy[d] > 0) begin
                m[d][D - busy[d]] = 16'h0;
                busy[d]--;
                e_rv[d]  = 1'b0;
                e_err[d] = 1'b0;
            end else begin
                bit acc = valid && !bd_en && !clr;
                logic [15:0] mask = {{8{strb[1]}}, {8{strb[0]}}};
                if (bd_en && bd_wr && int'(bd_addr) < D) m[d][bd_addr] = bd_wdata;
                if (bd_en && !bd_wr) e_bd[d] = int'(bd_addr) < D ? m[d][bd_addr] : 16'h0;
                e_rv[d]  = acc && !wr_rd;
                e_err[d] = acc && int'(addr) >= D;
                if (acc && !wr_rd) e_rd[d] = int'(addr) < D ? m[d][addr] : 16'h0;
                if (acc && wr_rd && int'(addr) < D)
                    m[d][addr] = (m[d][addr] & ~mask) | (wdata & mask);
                if (clr) busy[d] = D;
            end
        end
    endtask

    task automatic cyc();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("ready", d, 16'(rdy[d]), 16'(busy[d] == 0 && !bd_en && !clr));
            chk("bd_ready", d, 16'(bdr[d]), 16'(busy[d] == 0));
        end
        model();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rvalid", d, 16'(rv[d]), 16'(e_rv[d]));
            chk("err", d, 16'(er[d]), 16'(e_err[d]));
            chk("rdata", d, rd[d], e_rd[d]);
            chk("bd_rdata", d, bdd[d], e_bd[d]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, 16'(rdy[d]), 16'h0);
            chk("rst_rvalid", d, 16'(rv[d]), 16'h0);
            chk("rst_err", d, 16'(er[d]), 16'h0);
            chk("rst_rdata", d, rd[d], 16'h0);
            chk("rst_bd_rdata", d, bdd[d], 16'h0);
            chk("rst_bd_ready", d, 16'(bdr[d]), 16'h0);
            busy[d] = dep[d];
            e_rv[d] = 1'b0; e_err[d] = 1'b0; e_rd[d] = 16'h0; e_bd[d] = 16'h0;
        end
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic quiet(int n);
        valid = 1'b0; bd_en = 1'b0; clr = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic fd(bit w, int a, int wd, int s);
        valid = 1'b1; wr_rd = w; addr = 6'(a); wdata = 16'(wd); strb = 2'(s);
        bd_en = 1'b0; clr = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b0; valid = 1'b0; wr_rd = 1'b0; addr = '0; wdata = '0; strb = '0;
        clr = 1'b0; bd_en = 1'b0; bd_wr = 1'b0; bd_addr = '0; bd_wdata = '0;

        tbl[0]  = mk(1, 1, 5, 'hABCD, 1, 0, 0, 0, 0, 0, 'h0000, 0, 0, 'h0000);
        tbl[1]  = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 'h00CD, 1, 0, 'h0000);
        tbl[2]  = mk(1, 1, 50, 'h5555, 3, 0, 0, 0, 0, 0, 'h00CD, 0, 0, 'h0000);
        tbl[3]  = mk(1, 0, 50, 0, 0, 0, 0, 0, 0, 0, 'h5555, 1, 0, 'h0000);
        tbl[4]  = mk(1, 0, 7, 0, 0, 1, 1, 7, 'h1234, 0, 'h5555, 0, 0, 'h0000);
        tbl[5]  = mk(1, 0, 7, 0, 0, 1, 0, 7, 0, 0, 'h5555, 0, 0, 'h1234);
        tbl[6]  = mk(1, 0, 7, 0, 0, 1, 0, 5, 0, 0, 'h5555, 0, 0, 'h00CD);
        tbl[7]  = mk(1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 'h1234, 1, 0, 'h00CD);
        tbl[8]  = mk(1, 1, 3, 'hBEEF, 2, 0, 0, 0, 0, 0, 'h1234, 0, 0, 'h00CD);
        tbl[9]  = mk(1, 1, 3, 'h0011, 0, 0, 0, 0, 0, 0, 'h1234, 0, 0, 'h00CD);
        tbl[10] = mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 'hBE00, 1, 0, 'h00CD);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hBE00, 0, 0, 'h00CD);
        tbl[12] = mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 1, 'hBE00, 0, 0, 'h00CD);

        // Reset, abandon the first clearing pass midway, then run a full one.
        do_reset();
        quiet(10);
        do_reset();
        quiet(64);
        for (int k = 0; k < 4; k++) fd(0, $urandom_range(0, 63), 0, 0);

        for (int i = 0; i < 13; i++) begin
            valid = tbl[i].v; wr_rd = tbl[i].w; addr = tbl[i].a; wdata = tbl[i].wd;
            strb = tbl[i].s; bd_en = tbl[i].be; bd_wr = tbl[i].bw; bd_addr = tbl[i].ba;
            bd_wdata = tbl[i].bwd; clr = tbl[i].c;
            cyc();
            chk($sformatf("vec%0d_rdata", i), 0, rd[0], tbl[i].x_rd);
            chk($sformatf("vec%0d_rvalid", i), 0, 16'(rv[0]), 16'(tbl[i].x_rv));
            chk($sformatf("vec%0d_err", i), 0, 16'(er[0]), 16'(tbl[i].x_err));
            chk($sformatf("vec%0d_bd_rdata", i), 0, bdd[0], tbl[i].x_bd);
        end

        // Clear pass started by the last vector: addr 3 must read back as zero.
        quiet(64);
        fd(0, 3, 0, 0);
        chk("clr_rd3", 0, rd[0], 16'h0);
        chk("clr_rv3", 0, 16'(rv[0]), 16'h1);

        // Out-of-range access on the 48-word instance.
        fd(1, 50, 'h7777, 3);
        chk("oor_wr_err", 1, 16'(er[1]), 16'h1);
        chk("oor_wr_rv", 1, 16'(rv[1]), 16'h0);
        fd(0, 50, 0, 0);
        chk("oor_rd_data", 1, rd[1], 16'h0);
        chk("oor_rd_rv", 1, 16'(rv[1]), 16'h1);
        chk("oor_rd_err", 1, 16'(er[1]), 16'h1);
        fd(0, 2, 0, 0);
        chk("oor_no_alias", 1, rd[1], 16'h0);
        chk("inr_u64_err", 0, 16'(er[0]), 16'h0);

        for (int k = 0; k < 400; k++) begin
            valid = $urandom_range(0, 3) != 0;
            wr_rd = 1'($urandom);
            addr = 6'($urandom);
            wdata = 16'($urandom);
            strb = 2'($urandom);
            bd_en = $urandom_range(0, 4) == 0;
            bd_wr = 1'($urandom);
            bd_addr = 6'($urandom);
            bd_wdata = 16'($urandom);
            clr = $urandom_range(0, 80) == 0;
            cyc();
        end

        valid = 1'b0; bd_en = 1'b0; clr = 1'b0;
        for (int k = 0; k < 100 && (busy[0] != 0 || busy[1] != 0); k++) cyc();
        chk("idle_reached", 0, 16'(busy[0] | busy[1]), 16'h0);

        // Reset in the middle of a back-to-back read burst.
        for (int k = 0; k < 4; k++) fd(0, $urandom_range(0, 47), 0, 0);
        chk("burst_rv", 0, 16'(rv[0]), 16'h1);
        do_reset();
        quiet(64);
        for (int k = 0; k < 5; k++) fd(0, $urandom_range(0, 63), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
